// File: rtl/alu_pkg.sv
// alu_pkg
// Shared constants and helpers for the ALU built-in self-test.
//   - ALU control codes (6-bit) and the opcode table walked by the BIST
//   - Galois LFSR mask and MISR feedback polynomial
//   - bist_state_t sequencer states
//   - pure helper functions: LFSR step, MISR fold, reference ALU model
package alu_pkg;

    localparam logic [5:0] ALU_ADD  = 6'h20;
    localparam logic [5:0] ALU_SUB  = 6'h22;
    localparam logic [5:0] ALU_AND  = 6'h24;
    localparam logic [5:0] ALU_OR   = 6'h25;
    localparam logic [5:0] ALU_XOR  = 6'h26;
    localparam logic [5:0] ALU_NOR  = 6'h27;
    localparam logic [5:0] ALU_SLT  = 6'h2A;
    localparam logic [5:0] ALU_SLTU = 6'h2B;
    localparam logic [5:0] ALU_SLL  = 6'h00;
    localparam logic [5:0] ALU_SRL  = 6'h02;
    localparam logic [5:0] ALU_SRA  = 6'h03;

    localparam int NUM_OPS = 11;

    // Element 0 is the rightmost entry, so the walk starts at ADD.
    localparam logic [NUM_OPS-1:0][5:0] OP_TABLE = {
        ALU_SRA, ALU_SRL, ALU_SLL, ALU_SLTU, ALU_SLT, ALU_NOR,
        ALU_XOR, ALU_OR, ALU_AND, ALU_SUB, ALU_ADD
    };

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_FINISH
    } bist_state_t;

    // Right-shifting Galois LFSR: feedback taken from the bit shifted out.
    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? LFSR_MASK : 32'h0);
    endfunction

    // Left-shifting MISR with the ALU result folded in on every step.
    function automatic logic [31:0] misr_next(input logic [31:0] sig,
                                              input logic [31:0] data);
        return {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0) ^ data;
    endfunction

    // Behavioural ALU; shift amount comes from operand B, shifted value is A.
    function automatic logic [31:0] alu_ref(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [5:0]  cont);
        logic [31:0] r;
        r = 32'h0;
        case (cont)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_NOR:  r = ~(a | b);
            ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = $signed(a) >>> b[4:0];
            default:  r = 32'h0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_bist_misr.sv
// alu_bist_misr
// 32-bit multiple-input signature register used to compact ALU results.
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - asynchronous active-low reset, signature goes to zero
//   clear    - synchronous clear to zero (start of a new run), wins over enable
//   enable   - fold data into the signature this cycle
//   data     - 32-bit value to compact
//   sig      - current signature
module alu_bist_misr
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        enable,
    input  logic [31:0] data,
    output logic [31:0] sig
);

    // Signature register: cleared per run, advanced once per sampled vector.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sig <= 32'h0;
        end else if (clear) begin
            sig <= 32'h0;
        end else if (enable) begin
            sig <= misr_next(sig, data);
        end
    end

endmodule

// File: rtl/alu_bist.sv
// alu_bist
// Built-in self-test sequencer for the 32-bit ALU. Generates operands with
// two Galois LFSRs, walks the opcode table, and compacts every ALU result
// into a MISR. Each vector takes two cycles: DRIVE lets the ALU settle,
// SAMPLE folds the result and advances to the next vector.
// Optional build macro: ALU_BIST_REF_MODEL_EN adds a golden ALU model that
// checks every sample and reports the first failing vector.
// Ports:
//   clk, reset_n        - clock (rising edge), async active-low reset
//   start               - run request, accepted only in IDLE
//   alu_a, alu_b        - registered operands to the ALU
//   alu_cont            - registered 6-bit ALU control code
//   alu_result          - combinational result from the ALU
//   busy                - run in progress (DRIVE/SAMPLE)
//   done                - one-cycle pulse at the end of a run
//   pass                - result of the last run, cleared on a new start
//   signature           - current MISR value
//   fail_index/fail_seen - (ALU_BIST_REF_MODEL_EN only) first mismatching
//                          vector index and sticky mismatch flag
module alu_bist
    import alu_pkg::*;
#(
    parameter int          NUM_VECTORS = 256,
    parameter logic [31:0] SEED_A      = 32'h0000_0001,
    parameter logic [31:0] SEED_B      = 32'h1234_5678,
    parameter logic [31:0] GOLDEN_SIG  = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [5:0]  alu_cont,
    input  logic [31:0] alu_result,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] signature
`ifdef ALU_BIST_REF_MODEL_EN
    ,
    output logic [15:0] fail_index,
    output logic        fail_seen
`endif
);

    localparam logic [15:0] LAST_VEC = 16'(NUM_VECTORS - 1);
    localparam logic [3:0]  LAST_OP  = 4'(NUM_OPS - 1);

    bist_state_t state;
    bist_state_t state_next;
    logic        load;
    logic        step;
    logic [15:0] count;
    logic [3:0]  op_idx;
    logic [3:0]  op_next;
    logic        ref_ok;

    assign op_next = (op_idx == LAST_OP) ? 4'd0 : op_idx + 4'd1;
    assign busy    = (state == ST_DRIVE) || (state == ST_SAMPLE);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; load reseeds a run, step advances to the next vector.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                state_next = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                step       = 1'b1;
                state_next = (count == LAST_VEC) ? ST_FINISH : ST_DRIVE;
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operand/opcode generators and vector counter. The generators step once
    // more after the final sample; that extra value is never consumed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_a    <= SEED_A;
            alu_b    <= SEED_B;
            alu_cont <= OP_TABLE[0];
            op_idx   <= 4'd0;
            count    <= 16'd0;
        end else if (load) begin
            alu_a    <= SEED_A;
            alu_b    <= SEED_B;
            alu_cont <= OP_TABLE[0];
            op_idx   <= 4'd0;
            count    <= 16'd0;
        end else if (step) begin
            alu_a    <= lfsr_next(alu_a);
            alu_b    <= lfsr_next(alu_b);
            alu_cont <= OP_TABLE[op_next];
            op_idx   <= op_next;
            count    <= count + 16'd1;
        end
    end

    // done and pass leave FINISH together so pass is valid while done is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done <= 1'b0;
            pass <= 1'b0;
        end else begin
            done <= (state == ST_FINISH);
            if (load) begin
                pass <= 1'b0;
            end else if (state == ST_FINISH) begin
                pass <= (signature == GOLDEN_SIG) && ref_ok;
            end
        end
    end

    alu_bist_misr u_misr (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (load),
        .enable  (step),
        .data    (alu_result),
        .sig     (signature)
    );

`ifdef ALU_BIST_REF_MODEL_EN
    // Compare each sample with the golden model; only the first miss is kept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fail_seen  <= 1'b0;
            fail_index <= 16'hFFFF;
        end else if (load) begin
            fail_seen  <= 1'b0;
            fail_index <= 16'hFFFF;
        end else if (step && !fail_seen &&
                     (alu_result != alu_ref(alu_a, alu_b, alu_cont))) begin
            fail_seen  <= 1'b1;
            fail_index <= count;
        end
    end

    assign ref_ok = !fail_seen;
`else
    assign ref_ok = 1'b1;
`endif

endmodule

// File: tb/tb_alu_bist.sv
// tb_alu_bist
// Scoreboard bench for alu_bist. Two instances: a 4-vector one for timing
// and sequence checks, and a 256-vector one whose golden signature comes
// from the bench's own behavioural MISR. Issuing a run pushes its expected
// signature/pass/done-cycle into a queue; monitors pop on each done pulse.
// Build with ALU_BIST_REF_MODEL_EN to also exercise fail_index/fail_seen.
module tb_alu_bist;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] sig;
        logic        pass;
        int          doneCyc;
        logic [15:0] failIdx;
        logic        failSeen;
    } exp_t;

    localparam logic [31:0] SEED_A = 32'h0000_0001;
    localparam logic [31:0] SEED_B = 32'h1234_5678;

    // Bench-side models, written from the behavioural description.
    function automatic logic [31:0] benchLfsr(input logic [31:0] x);
        logic [31:0] n;
        n = x >> 1;
        if (x[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    function automatic logic [31:0] benchMisr(input logic [31:0] s, input logic [31:0] r);
        logic [31:0] n;
        n = {s[30:0], 1'b0};
        if (s[31]) n = n ^ 32'h04C1_1DB7;
        return n ^ r;
    endfunction

    function automatic logic [5:0] benchOp(input int v);
        case (v % 11)
            0:  return ALU_ADD;
            1:  return ALU_SUB;
            2:  return ALU_AND;
            3:  return ALU_OR;
            4:  return ALU_XOR;
            5:  return ALU_NOR;
            6:  return ALU_SLT;
            7:  return ALU_SLTU;
            8:  return ALU_SLL;
            9:  return ALU_SRL;
            default: return ALU_SRA;
        endcase
    endfunction

    function automatic logic [31:0] benchAlu(input logic [31:0] a, input logic [31:0] b, input logic [5:0] c);
        logic signed [31:0] sa;
        sa = a;
        case (c)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_NOR:  return ~(a | b);
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return 32'(sa >>> b[4:0]);
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] faultResult(input logic [31:0] r, input int v, input int stuck, input int corruptIdx);
        logic [31:0] f;
        f = r;
        if (stuck != 0) f[0] = 1'b0;
        if (v == corruptIdx) f = f ^ 32'h0000_0100;
        return f;
    endfunction

    function automatic logic [31:0] modelSig(input int n, input int stuck, input int corruptIdx);
        logic [31:0] a, b, s;
        a = SEED_A;
        b = SEED_B;
        s = 32'h0;
        for (int v = 0; v < n; v++) begin
            s = benchMisr(s, faultResult(benchAlu(a, b, benchOp(v)), v, stuck, corruptIdx));
            a = benchLfsr(a);
            b = benchLfsr(b);
        end
        return s;
    endfunction

    function automatic logic [15:0] modelFirstFail(input int n, input int stuck, input int corruptIdx);
        logic [31:0] a, b, r;
        a = SEED_A;
        b = SEED_B;
        for (int v = 0; v < n; v++) begin
            r = benchAlu(a, b, benchOp(v));
            if (faultResult(r, v, stuck, corruptIdx) != r) return 16'(v);
            a = benchLfsr(a);
            b = benchLfsr(b);
        end
        return 16'hFFFF;
    endfunction

    localparam logic [31:0] GOLDEN256 = modelSig(256, 0, -1);

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start4 = 1'b0;
    logic        start256 = 1'b0;
    logic        stuck0 = 1'b0;
    logic        corruptOn = 1'b0;
    logic [31:0] corruptA = 32'h0;
    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;

    logic [31:0] a4, b4, res4, sig4;
    logic [5:0]  c4;
    logic        busy4, done4, pass4;
    logic [31:0] a256, b256, res256, sig256;
    logic [5:0]  c256;
    logic        busy256, done256, pass256;
`ifdef ALU_BIST_REF_MODEL_EN
    logic [15:0] failIdx4, failIdx256;
    logic        failSeen4, failSeen256;
`endif

    exp_t q4[$];
    exp_t q256[$];
    exp_t e4, e256;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    alu_bist #(.NUM_VECTORS(4)) u4 (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start4),
        .alu_a      (a4),
        .alu_b      (b4),
        .alu_cont   (c4),
        .alu_result (res4),
        .busy       (busy4),
        .done       (done4),
        .pass       (pass4),
        .signature  (sig4)
`ifdef ALU_BIST_REF_MODEL_EN
        ,
        .fail_index (failIdx4),
        .fail_seen  (failSeen4)
`endif
    );

    alu_bist #(.NUM_VECTORS(256), .GOLDEN_SIG(GOLDEN256)) u256 (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start256),
        .alu_a      (a256),
        .alu_b      (b256),
        .alu_cont   (c256),
        .alu_result (res256),
        .busy       (busy256),
        .done       (done256),
        .pass       (pass256),
        .signature  (sig256)
`ifdef ALU_BIST_REF_MODEL_EN
        ,
        .fail_index (failIdx256),
        .fail_seen  (failSeen256)
`endif
    );

    // The bench plays the ALU; the large instance can have faults injected.
    assign res4 = benchAlu(a4, b4, c4);

    always_comb begin
        res256 = benchAlu(a256, b256, c256);
        if (stuck0) res256[0] = 1'b0;
        if (corruptOn && (a256 == corruptA)) res256 = res256 ^ 32'h0000_0100;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    endtask

    // Monitor for the 4-vector instance: every done pulse must match a queued run.
    always @(negedge clk) begin
        if (done4 === 1'b1) begin
            if (q4.size() == 0) begin
                checkOutput("u4 unexpected done", 32'(done4), 32'd0);
            end else begin
                e4 = q4.pop_front();
                checkOutput("u4 done cycle", cyc, e4.doneCyc);
                checkOutput("u4 signature", sig4, e4.sig);
                checkOutput("u4 pass", 32'(pass4), 32'(e4.pass));
`ifdef ALU_BIST_REF_MODEL_EN
                checkOutput("u4 fail_index", 32'(failIdx4), 32'(e4.failIdx));
                checkOutput("u4 fail_seen", 32'(failSeen4), 32'(e4.failSeen));
`endif
            end
        end
    end

    // Monitor for the 256-vector instance.
    always @(negedge clk) begin
        if (done256 === 1'b1) begin
            if (q256.size() == 0) begin
                checkOutput("u256 unexpected done", 32'(done256), 32'd0);
            end else begin
                e256 = q256.pop_front();
                checkOutput("u256 done cycle", cyc, e256.doneCyc);
                checkOutput("u256 signature", sig256, e256.sig);
                checkOutput("u256 pass", 32'(pass256), 32'(e256.pass));
`ifdef ALU_BIST_REF_MODEL_EN
                checkOutput("u256 fail_index", 32'(failIdx256), 32'(e256.failIdx));
                checkOutput("u256 fail_seen", 32'(failSeen256), 32'(e256.failSeen));
`endif
            end
        end
    end

    // Issue a start (held for 'runs' back-to-back runs) and queue expectations.
    task automatic applyStimulus(input int which, input int n, input int stuck, input int corruptIdx,
                                 input int runs, input bit expectDone, output int startCyc);
        exp_t        e;
        logic [31:0] a;
        logic [31:0] golden;
        @(negedge clk);
        stuck0    = (stuck != 0);
        corruptOn = (corruptIdx >= 0);
        a = SEED_A;
        for (int v = 0; v < corruptIdx; v++) a = benchLfsr(a);
        corruptA = a;
        if (which == 4) start4 = 1'b1;
        else start256 = 1'b1;
        @(posedge clk);
        #1;
        startCyc = cyc;
        golden = (which == 4) ? 32'h0 : GOLDEN256;
        if (expectDone) begin
            for (int r = 0; r < runs; r++) begin
                e.sig      = modelSig(n, stuck, corruptIdx);
                e.failIdx  = modelFirstFail(n, stuck, corruptIdx);
                e.failSeen = (e.failIdx != 16'hFFFF);
                e.pass     = (e.sig == golden);
`ifdef ALU_BIST_REF_MODEL_EN
                e.pass     = e.pass && !e.failSeen;
`endif
                e.doneCyc  = startCyc + r * (2 * n + 2) + 2 * n + 1;
                if (which == 4) q4.push_back(e);
                else q256.push_back(e);
            end
        end
        if (runs > 1) begin
            repeat ((runs - 1) * (2 * n + 2)) @(posedge clk);
            #1;
        end
        start4   = 1'b0;
        start256 = 1'b0;
    endtask

    task automatic waitDrain(input int which, input int maxCyc);
        int left;
        for (int i = 0; i < maxCyc; i++) begin
            left = (which == 4) ? q4.size() : q256.size();
            if (left == 0) break;
            @(posedge clk);
        end
        left = (which == 4) ? q4.size() : q256.size();
        checkOutput($sformatf("u%0d runs completed", which), left, 32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " u4 alu_a"}, a4, 32'h0000_0001);
        checkOutput({tag, " u4 alu_b"}, b4, 32'h1234_5678);
        checkOutput({tag, " u4 alu_cont"}, 32'(c4), 32'(ALU_ADD));
        checkOutput({tag, " u4 busy"}, 32'(busy4), 32'd0);
        checkOutput({tag, " u4 done"}, 32'(done4), 32'd0);
        checkOutput({tag, " u4 signature"}, sig4, 32'h0);
        checkOutput({tag, " u256 alu_a"}, a256, 32'h0000_0001);
        checkOutput({tag, " u256 alu_b"}, b256, 32'h1234_5678);
        checkOutput({tag, " u256 alu_cont"}, 32'(c256), 32'(ALU_ADD));
        checkOutput({tag, " u256 busy"}, 32'(busy256), 32'd0);
        checkOutput({tag, " u256 done"}, 32'(done256), 32'd0);
        checkOutput({tag, " u256 pass"}, 32'(pass256), 32'd0);
        checkOutput({tag, " u256 signature"}, sig256, 32'h0);
`ifdef ALU_BIST_REF_MODEL_EN
        checkOutput({tag, " u256 fail_index"}, 32'(failIdx256), 32'h0000_FFFF);
        checkOutput({tag, " u256 fail_seen"}, 32'(failSeen256), 32'd0);
`endif
    endtask

    // Watchdog: a hung run still ends with a FAIL line.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d passed %0d", checks, passes);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          s;
        int          busyCnt;
        logic [31:0] expA [4];
        logic [5:0]  expOp [4];
        logic [31:0] bv;

        expA[0] = 32'h0000_0001;
        expA[1] = 32'h8020_0003;
        expA[2] = 32'hC030_0002;
        expA[3] = 32'h6018_0001;
        expOp[0] = ALU_ADD;
        expOp[1] = ALU_SUB;
        expOp[2] = ALU_AND;
        expOp[3] = ALU_OR;

        // Reset state with no start.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetValues("reset");
        reset_n = 1'b1;

        // Short run: vector sequence, busy length, done timing via the monitor.
        applyStimulus(4, 4, 0, -1, 1, 1'b1, s);
        busyCnt = 0;
        bv = SEED_B;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if ((k % 2 == 0) && (k < 8)) begin
                checkOutput($sformatf("u4 alu_a vec%0d", k / 2), a4, expA[k / 2]);
                checkOutput($sformatf("u4 alu_b vec%0d", k / 2), b4, bv);
                checkOutput($sformatf("u4 alu_cont vec%0d", k / 2), 32'(c4), 32'(expOp[k / 2]));
                bv = benchLfsr(bv);
            end
            if (busy4) busyCnt++;
        end
        checkOutput("u4 busy cycles", busyCnt, 32'd8);
        waitDrain(4, 50);

        // start held through a run: one done per run, next run right after IDLE.
        applyStimulus(4, 4, 0, -1, 2, 1'b1, s);
        waitDrain(4, 60);

        // Full clean run, then result bit 0 stuck at zero.
        applyStimulus(256, 256, 0, -1, 1, 1'b1, s);
        waitDrain(256, 600);
        applyStimulus(256, 256, 1, -1, 1, 1'b1, s);
        checkOutput("u256 pass cleared on start", 32'(pass256), 32'd0);
        waitDrain(256, 600);
        checkOutput("u256 stuck signature differs", 32'(sig256 != GOLDEN256), 32'd1);

        // Reset mid-run: asynchronous return to reset values, no done pulse.
        applyStimulus(256, 256, 0, -1, 1, 1'b0, s);
        repeat (200) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkResetValues("async reset");
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(256, 256, 0, -1, 1, 1'b1, s);
        waitDrain(256, 600);

`ifdef ALU_BIST_REF_MODEL_EN
        // Single corrupted result at vector 37.
        applyStimulus(256, 256, 0, 37, 1, 1'b1, s);
        waitDrain(256, 600);
        checkOutput("u256 corrupt fail_index", 32'(failIdx256), 32'd37);
        checkOutput("u256 corrupt fail_seen", 32'(failSeen256), 32'd1);
`endif

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
